rd_reg: RTL and testbench

RD_REG -- requirements
Module: rd_reg

---
 rtl/rd_reg_pkg.sv | 46 ++++
 rtl/rd_reg_if.sv | 28 ++
 rtl/rise_det.sv | 29 ++
 rtl/rd_reg.sv | 117 +++++++++++
 tb/tb_rd_reg.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rd_reg_pkg.sv
// Shared definitions for the register read path and its write-side partner:
// FSM state encoding, wait-state limits and the select-priority helper.
package rd_reg_pkg;

  // Largest supported number of wait-state cycles and the counter width.
  localparam int HOLD_MAX = 7;
  localparam int CNT_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT,
    ST_ACK,
    ST_RELEASE
  } rd_state_e;

  // Register selects as captured at read start.
  typedef struct packed {
    logic cs1;
    logic cs2;
    logic cs3;
  } sel_t;

  typedef enum logic [1:0] {
    SRC_REG1,
    SRC_REG2,
    SRC_REG3,
    SRC_NONE
  } src_e;

  // Keep a wait-state request inside the range the counter can express.
  function automatic int clamp_hold(input int hold);
    if (hold < 0)        return 0;
    if (hold > HOLD_MAX) return HOLD_MAX;
    return hold;
  endfunction

  // Fixed priority: Reg1 over Reg2 over Reg3; nothing selected is an error read.
  function automatic src_e pick_src(input sel_t sel);
    if (sel.cs1) return SRC_REG1;
    if (sel.cs2) return SRC_REG2;
    if (sel.cs3) return SRC_REG3;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/rd_reg_if.sv
// Host-side read bus plus the register contents supplied by the write side.
interface rd_reg_if #(
  parameter int DW = 8
);
  logic          my_rd;
  logic          CS_Reg1;
  logic          CS_Reg2;
  logic          CS_Reg3;
  logic [DW-1:0] Reg1;
  logic [DW-1:0] Reg2;
  logic [DW-1:0] Reg3;
  logic [DW-1:0] Data_out;
  logic          rd_ack;
  logic          rd_err;
  logic          busy;

  // Host / write-side view: drives requests and register contents.
  modport master (
    output my_rd, CS_Reg1, CS_Reg2, CS_Reg3, Reg1, Reg2, Reg3,
    input  Data_out, rd_ack, rd_err, busy
  );

  // Read block view.
  modport slave (
    input  my_rd, CS_Reg1, CS_Reg2, CS_Reg3, Reg1, Reg2, Reg3,
    output Data_out, rd_ack, rd_err, busy
  );
endinterface

// File: rtl/rise_det.sv
// Rising-edge detector for a level request. It only reports a rise after it
// has seen the input low at least once since reset, so a request that is
// already high when reset releases never looks like a fresh edge.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic armed_q;

  // Track the previous input level and whether a low has been observed.
  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      in_q    <= in;
      armed_q <= armed_q | ~in;
    end
  end

  assign rise = in & ~in_q & armed_q;

endmodule

// File: rtl/rd_reg.sv
// Register read port: detects a read request edge, latches the selects,
// captures the chosen register, optionally inserts wait states, then pulses
// rd_ack (and rd_err for an empty select) and waits for the request to drop.
module rd_reg
  import rd_reg_pkg::*;
#(
  parameter int DW       = 8,
  parameter int HOLD_CYC = 0
) (
  input logic     clk,
  input logic     rst,
  rd_reg_if.slave bus
);

  localparam int HOLD_EFF = clamp_hold(HOLD_CYC);
  // Counter value on the last wait cycle; unused when there are no wait states.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_EFF == 0) ? 0 : HOLD_EFF - 1);

  rd_state_e        state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_arm_q, err_arm_d;
  logic [DW-1:0]    data_q, data_d;
  logic             ack_q, err_q, busy_q;
  logic             rd_rise;

  rise_det u_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (bus.my_rd),
    .rise (rd_rise)
  );

  // FSM state, latched selects, wait counter and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      err_arm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      err_arm_q <= err_arm_d;
    end
  end

  // Next-state logic and capture-data selection.
  always_comb begin
    // NOTE: every signal assigned here gets a hold default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    err_arm_d = err_arm_q;
    data_d    = data_q;

    case (state_q)
      ST_IDLE: begin
        if (rd_rise) begin
          state_d = ST_CAPTURE;
          sel_d   = '{cs1: bus.CS_Reg1, cs2: bus.CS_Reg2, cs3: bus.CS_Reg3};
        end
      end

      ST_CAPTURE: begin
        err_arm_d = 1'b0;
        case (pick_src(sel_q))
          SRC_REG1: data_d = bus.Reg1;
          SRC_REG2: data_d = bus.Reg2;
          SRC_REG3: data_d = bus.Reg3;
          default: begin
            data_d    = '0;
            err_arm_d = 1'b1;
          end
        endcase
        cnt_d   = '0;
        state_d = (HOLD_EFF > 0) ? ST_WAIT : ST_ACK;
      end

      ST_WAIT: begin
        if (cnt_q == HOLD_LAST) state_d = ST_ACK;
        else                    cnt_d   = cnt_q + 1'b1;
      end

      ST_ACK: state_d = ST_RELEASE;

      ST_RELEASE: begin
        if (!bus.my_rd) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs: read data, one-cycle ack/error pulses and busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      ack_q  <= (state_q == ST_ACK);
      err_q  <= (state_q == ST_ACK) && err_arm_q;
      busy_q <= (state_d != ST_IDLE);
    end
  end

  assign bus.Data_out = data_q;
  assign bus.rd_ack   = ack_q;
  assign bus.rd_err   = err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rd_reg.sv
// Directed bench for rd_reg: one instance without wait states, one with three.
module tb_rd_reg;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  rd_reg_if #(.DW(8)) bus0 ();
  rd_reg_if #(.DW(8)) bus3 ();

  rd_reg #(.DW(8), .HOLD_CYC(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  rd_reg #(.DW(8), .HOLD_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? bus0.rd_ack : bus3.rd_ack;
  endfunction

  function automatic logic err_of(input int sel);
    return (sel == 0) ? bus0.rd_err : bus3.rd_err;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus0.busy : bus3.busy;
  endfunction

  function automatic logic [7:0] data_of(input int sel);
    return (sel == 0) ? bus0.Data_out : bus3.Data_out;
  endfunction

  task automatic set_rd(input int sel, input logic v);
    if (sel == 0) bus0.my_rd = v;
    else          bus3.my_rd = v;
  endtask

  task automatic set_sel(input int sel, input logic c1, input logic c2, input logic c3);
    if (sel == 0) begin
      bus0.CS_Reg1 = c1; bus0.CS_Reg2 = c2; bus0.CS_Reg3 = c3;
    end else begin
      bus3.CS_Reg1 = c1; bus3.CS_Reg2 = c2; bus3.CS_Reg3 = c3;
    end
  endtask

  task automatic set_regs(input int sel, input logic [7:0] r1, input logic [7:0] r2,
                          input logic [7:0] r3);
    if (sel == 0) begin
      bus0.Reg1 = r1; bus0.Reg2 = r2; bus0.Reg3 = r3;
    end else begin
      bus3.Reg1 = r1; bus3.Reg2 = r2; bus3.Reg3 = r3;
    end
  endtask

  // Raise my_rd just after a rising edge; lat = edges after the start edge
  // until rd_ack is seen (-1 on timeout). Optionally disturb the inputs.
  task automatic run_read(input int sel, input int poke_at, input int drop_at, output int lat);
    lat = -1;
    @(posedge clk); #1;
    set_rd(sel, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 0) check("busy_at_start", busy_of(sel), 1);
      if (ack_of(sel)) begin
        lat = n;
        break;
      end
      if (n == poke_at) begin
        set_regs(sel, 8'h11, 8'h22, 8'hFF);
        set_sel(sel, 1'b1, 1'b0, 1'b0);
      end
      if (n == drop_at) set_rd(sel, 1'b0);
    end
  endtask

  task automatic end_read(input int sel);
    @(posedge clk); #1;
    set_rd(sel, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;
    int busy_seen;

    rst = 1'b0;
    set_rd(0, 1'b0); set_rd(3, 1'b0);
    set_sel(0, 1'b0, 1'b0, 1'b0); set_sel(3, 1'b0, 1'b0, 1'b0);
    set_regs(0, 8'h00, 8'h00, 8'h00); set_regs(3, 8'h00, 8'h00, 8'h00);
    #12;
    check("rst_data0", bus0.Data_out, 8'h00);
    check("rst_ack0",  bus0.rd_ack,   1'b0);
    check("rst_err0",  bus0.rd_err,   1'b0);
    check("rst_busy0", bus0.busy,     1'b0);
    check("rst_data3", bus3.Data_out, 8'h00);
    check("rst_busy3", bus3.busy,     1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic read of Reg1, no wait states.
    set_regs(0, 8'h5A, 8'h00, 8'h00);
    set_sel(0, 1'b1, 1'b0, 1'b0);
    run_read(0, -1, -1, lat);
    check("t1_latency", lat, 2);
    check("t1_data", data_of(0), 8'h5A);
    check("t1_err", err_of(0), 1'b0);
    @(negedge clk);
    check("t1_ack_one_cycle", ack_of(0), 1'b0);
    end_read(0);
    check("t1_busy_idle", busy_of(0), 1'b0);

    // Priority: Reg2 wins over Reg3 when Reg1 is not selected.
    set_regs(0, 8'h77, 8'h22, 8'h33);
    set_sel(0, 1'b0, 1'b1, 1'b1);
    run_read(0, -1, -1, lat);
    check("t2_latency", lat, 2);
    check("t2_data", data_of(0), 8'h22);
    check("t2_err", err_of(0), 1'b0);
    end_read(0);

    // No select: zero data, ack and error together.
    set_sel(0, 1'b0, 1'b0, 1'b0);
    run_read(0, -1, -1, lat);
    check("t3_latency", lat, 2);
    check("t3_data", data_of(0), 8'h00);
    check("t3_err", err_of(0), 1'b1);
    @(negedge clk);
    check("t3_err_one_cycle", err_of(0), 1'b0);
    end_read(0);

    // Three wait states; register and select changes during WAIT are ignored.
    set_regs(3, 8'h11, 8'h22, 8'hC3);
    set_sel(3, 1'b0, 1'b0, 1'b1);
    run_read(3, 1, -1, lat);
    check("t4_latency", lat, 5);
    check("t4_data", data_of(3), 8'hC3);
    check("t4_err", err_of(3), 1'b0);
    @(negedge clk);
    check("t4_ack_one_cycle", ack_of(3), 1'b0);
    end_read(3);
    check("t4_data_held", data_of(3), 8'hC3);

    // my_rd held high for 10 cycles: one ack; data holds; busy drops after release.
    set_regs(0, 8'hA5, 8'h00, 8'h00);
    set_sel(0, 1'b1, 1'b0, 1'b0);
    acks = 0;
    @(posedge clk); #1;
    set_rd(0, 1'b1);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_of(0)) acks++;
    end
    check("t5_single_ack", acks, 1);
    set_regs(0, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    set_rd(0, 1'b0);
    @(negedge clk);
    check("t5_busy_before_edge", busy_of(0), 1'b1);
    @(negedge clk);
    check("t5_busy_fall", busy_of(0), 1'b0);
    check("t5_data_held", data_of(0), 8'hA5);

    // my_rd dropped right after start: read completes, then leaves RELEASE.
    set_regs(3, 8'h11, 8'h6B, 8'h00);
    set_sel(3, 1'b0, 1'b1, 1'b0);
    run_read(3, -1, 0, lat);
    check("t6_latency", lat, 5);
    check("t6_data", data_of(3), 8'h6B);
    @(negedge clk);
    check("t6_busy_exit", busy_of(3), 1'b0);
    check("t6_ack_one_cycle", ack_of(3), 1'b0);

    // Reset during WAIT discards the read; held request needs a fresh edge.
    set_regs(3, 8'h99, 8'h00, 8'h00);
    set_sel(3, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_rd(3, 1'b1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("t7_busy_in_wait", busy_of(3), 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_ack", ack_of(3), 1'b0);
    check("t7_rst_data", data_of(3), 8'h00);
    check("t7_rst_busy", busy_of(3), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    busy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack_of(3))  acks++;
      if (busy_of(3)) busy_seen++;
    end
    check("t7_no_ack_held_high", acks, 0);
    check("t7_no_busy_held_high", busy_seen, 0);
    @(posedge clk); #1;
    set_rd(3, 1'b0);
    run_read(3, -1, -1, lat);
    check("t7_reedge_latency", lat, 5);
    check("t7_reedge_data", data_of(3), 8'h99);
    end_read(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
